harmonic_sequencer: RTL

Per-sample harmonic phase sequencer for the additive oscillator. On each sample-rate strobe it walks harmonics 0..N-1 in turn:
- reads each harmonic's stored position from the sample position RAM (asynchronous read);
- adds that harmonic's increment, freq × (h+1), and writes the result back;
- emits the new position with its harmonic index to the sine-lookup/mix stage.

It sits between the frequency/control front end and the sample position RAM, driving that RAM's address, data and write-enable.

---
 rtl/harmonic_sequencer_pkg.sv | 18 +
 rtl/harmonic_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/harmonic_sequencer_pkg.sv
// Shared types and defaults for the additive-oscillator harmonic phase sequencer.
package harmonic_sequencer_pkg;

    localparam int unsigned DefaultPosWidth  = 16;
    localparam int unsigned DefaultHarmWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCalc  = 2'd1,
        StDrain = 2'd2
    } hs_state_e;

    // Half of the phase range: an increment at or above this aliases.
    function automatic logic [63:0] nyquist_threshold(input int unsigned width);
        return 64'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/harmonic_sequencer.sv
// Per-sample harmonic phase sequencer: read-modify-writes each harmonic's phase position in an
// external RAM and streams the updated positions to the sine-lookup/mix stage.
module harmonic_sequencer
    import harmonic_sequencer_pkg::*;
#(
    parameter int unsigned POS_WIDTH  = DefaultPosWidth,
    parameter int unsigned HARM_WIDTH = DefaultHarmWidth
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_strobe,
    input  logic [POS_WIDTH-1:0]  freq,
    input  logic [HARM_WIDTH-1:0] harm_count,
    input  logic                  phase_sync,
    output logic [HARM_WIDTH-1:0] ram_addr,
    output logic [POS_WIDTH-1:0]  ram_din,
    output logic                  ram_we,
    input  logic [POS_WIDTH-1:0]  ram_dout,
    output logic [POS_WIDTH-1:0]  out_pos,
    output logic [HARM_WIDTH-1:0] out_harm,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned SumWidth = POS_WIDTH + 2;
    localparam logic [SumWidth-1:0] NyqLimit = SumWidth'(nyquist_threshold(POS_WIDTH));

    hs_state_e             r_state;
    logic [POS_WIDTH-1:0]  r_freq;
    logic [HARM_WIDTH-1:0] r_harm_count;
    logic                  r_sync;
    logic [HARM_WIDTH-1:0] r_h;
    logic [POS_WIDTH:0]    r_inc;
    logic [POS_WIDTH-1:0]  r_out_pos;
    logic [HARM_WIDTH-1:0] r_out_harm;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_overrun;

    hs_state_e             w_state_next;
    logic [POS_WIDTH-1:0]  w_freq_next;
    logic [HARM_WIDTH-1:0] w_harm_count_next;
    logic                  w_sync_next;
    logic [HARM_WIDTH-1:0] w_h_next;
    logic [POS_WIDTH:0]    w_inc_next;
    logic [POS_WIDTH-1:0]  w_out_pos_next;
    logic [HARM_WIDTH-1:0] w_out_harm_next;
    logic                  w_out_valid_next;
    logic                  w_out_last_next;

    logic                  w_busy;
    logic                  w_out_free;
    logic                  w_calc_fire;
    logic [POS_WIDTH-1:0]  w_base;
    logic [POS_WIDTH-1:0]  w_new_pos;
    logic [SumWidth-1:0]   w_inc_sum;
    logic [HARM_WIDTH-1:0] w_h_final;
    logic                  w_last;

    assign w_busy      = (r_state != StIdle);
    assign w_out_free  = !r_out_valid || out_ready;
    assign w_calc_fire = (r_state == StCalc) && w_out_free;

    assign w_base    = r_sync ? '0 : ram_dout;
    assign w_new_pos = w_base + r_inc[POS_WIDTH-1:0];

    // The increment of the next harmonic decides whether this one closes the frame.
    assign w_inc_sum = SumWidth'(r_inc) + SumWidth'(r_freq);
    assign w_h_final = r_harm_count - HARM_WIDTH'(1);
    assign w_last    = (r_h == w_h_final) || (w_inc_sum >= NyqLimit);

    assign ram_addr = r_h;
    assign ram_din  = (r_state == StCalc) ? w_new_pos : '0;
    assign ram_we   = w_calc_fire;

    assign out_pos   = r_out_pos;
    assign out_harm  = r_out_harm;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = w_busy;
    assign overrun   = r_overrun;

    always_comb begin
        w_state_next      = r_state;
        w_freq_next       = r_freq;
        w_harm_count_next = r_harm_count;
        w_sync_next       = r_sync;
        w_h_next          = r_h;
        w_inc_next        = r_inc;
        w_out_pos_next    = r_out_pos;
        w_out_harm_next   = r_out_harm;
        w_out_valid_next  = r_out_valid && !out_ready;
        w_out_last_next   = r_out_last;

        unique case (r_state)
            StIdle: begin
                if (sample_strobe && (harm_count != '0)) begin
                    w_freq_next       = freq;
                    w_harm_count_next = harm_count;
                    w_sync_next       = phase_sync;
                    w_h_next          = '0;
                    w_inc_next        = {1'b0, freq};
                    w_state_next      = StCalc;
                end
            end
            StCalc: begin
                if (w_out_free) begin
                    w_out_pos_next   = w_new_pos;
                    w_out_harm_next  = r_h;
                    w_out_valid_next = 1'b1;
                    w_out_last_next  = w_last;
                    if (w_last) begin
                        w_state_next = StDrain;
                    end else begin
                        w_h_next   = r_h + HARM_WIDTH'(1);
                        w_inc_next = w_inc_sum[POS_WIDTH:0];
                    end
                end
            end
            StDrain: begin
                if (r_out_valid && out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_freq       <= '0;
            r_harm_count <= '0;
            r_sync       <= 1'b0;
            r_h          <= '0;
            r_inc        <= '0;
            r_out_pos    <= '0;
            r_out_harm   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_freq       <= w_freq_next;
            r_harm_count <= w_harm_count_next;
            r_sync       <= w_sync_next;
            r_h          <= w_h_next;
            r_inc        <= w_inc_next;
            r_out_pos    <= w_out_pos_next;
            r_out_harm   <= w_out_harm_next;
            r_out_valid  <= w_out_valid_next;
            r_out_last   <= w_out_last_next;
            r_overrun    <= sample_strobe && w_busy;
        end
    end

endmodule
